cfg_fetch: RTL and testbench
============================

CFG_FETCH -- requirements
Module: cfg_fetch

Interface
REQ-001 SHALL have parameter CFG_BASE, default 32'h0800_0000, meaning the byte address of layer-0 config word in DDR.
REQ-002 SHALL have parameter ADDR_WIDTH, default 32, meaning the AXI address width.
REQ-003 SHALL have these ports, one clock domain (clk); reset asynchronous, active-low (rst_n):
- clk  in  1  clock
- rst_n  in  1  async active-low reset
- start  in  1  fetch request pulse
- layer_idx  in  8  layer entry to fetch (0..255)
- busy  out  1  fetch in progress
- done  out  1  one-cycle pulse, fetch completed OK
- err  out  1  one-cycle pulse, fetch failed
- cfg_valid  out  1  level, cfg_* hold a good word
- cfg_pool  out  9  word[8:0]
- cfg_numlay  out  8  word[16:9]
- cfg_numfiltg  out  9  word[25:17]
- cfg_numpat  out  8  word[33:26]
- cfg_numfrm  out  5  word[38:34]
- cfg_numblk  out  5  word[43:39]
- cfg_depblk  out  5  word[48:44]
- cfg_lenrow  out  4  word[52:49]
- cfg_prio  out  6  word[58:53]; word[63:59] ignored
- m_axi_araddr  out  ADDR_WIDTH  read address
- m_axi_arlen  out  8  constant 1 (2 beats)
- m_axi_arsize  out  3  constant 3'b010
- m_axi_arburst  out  2  constant 2'b01 INCR
- m_axi_arvalid / m_axi_arready  out / in  1  AR handshake
- m_axi_rdata  in  32  read data
- m_axi_rresp  in  2  read response
- m_axi_rlast  in  1  last beat
- m_axi_rvalid / m_axi_rready  in / out  1  R handshake

Function
REQ-004 SHALL implement FSM IDLE -> ADDR -> DATA -> IDLE.
REQ-005 IDLE: start=1 at edge N -> latch layer_idx, araddr = CFG_BASE + layer_idx*8 (wraps mod 2^ADDR_WIDTH), enter ADDR; arvalid=1 and busy=1 from N+1.
REQ-006 start while busy SHALL be ignored; no queuing.
REQ-007 ADDR: arvalid and araddr held stable until arready=1; handshake cycle -> DATA, arvalid=0 next cycle.
REQ-008 DATA: rready=1; 1-bit beat counter; beat 0 -> word[31:0], beat 1 -> word[63:32] (little-endian, lowest address first).
REQ-009 Beat accepted only when rvalid && rready; rvalid low stalls indefinitely.
REQ-010 Beat 1 accepted with rlast=1 and both rresp==2'b00 -> cfg_* updated and done=1 on next edge, cfg_valid=1, busy=0, return to IDLE.
REQ-011 Any beat with rresp!=0, rlast=1 on beat 0, or rlast=0 on beat 1 -> sticky internal fault; after beat 1 accepted (or at beat 0 if rlast=1 there), err=1 one cycle, cfg_* and cfg_valid unchanged, return to IDLE.
REQ-012 done and err SHALL never assert together; each exactly one cycle per fetch.
REQ-013 start accepted in same cycle as done/err SHALL be ignored (FSM not yet IDLE); accepted from next cycle.
REQ-014 Minimum latency, arready and rvalid tied high: start@N, AR handshake N+1, beats N+2, N+3, done N+4.
REQ-015 Outputs SHALL be registered; no combinational path from AXI inputs to cfg_*/done/err.

Reset
REQ-016 rst_n=0 SHALL asynchronously force IDLE, arvalid=0, rready=0, busy=0, done=0, err=0, cfg_valid=0, all cfg_*=0, araddr=0.
REQ-017 Reset mid-fetch SHALL abandon the transaction; no partial word reaches cfg_*.

Verification
- Word 0x065F_F0BC_3C0E_0E0A at CFG_BASE (beats 0x3C0E0E0A, 0x065FF0BC), start, layer_idx=0, ready/valid high -> done at N+4; pool=10, numlay=7, numfiltg=7, numpat=15, numfrm=15, numblk=1, depblk=31, lenrow=15, prio=0x32.
- layer_idx=255 -> araddr=0x0800_07F8; arready held low 5 cycles -> araddr/arvalid stable throughout, done after data.
- rresp=2'b10 on beat 1 -> err pulse, cfg_* keep previous values, cfg_valid unchanged.
- rlast=1 on beat 0 -> err pulse at next edge, FSM IDLE, subsequent start fetches normally.
- start re-pulsed during DATA and with rvalid gapped 3 cycles between beats -> single AR, single done, correct word.
- rst_n low during DATA after beat 0 -> all outputs 0 immediately; following fetch returns full correct word.

Source files
------------

// File: rtl/cfg_fetch.sv
// Per-layer config fetcher: reads one 64-bit word from DDR over a
// two-beat AXI read burst and presents it as decoded cfg_* fields.
module cfg_fetch #(
  parameter int ADDR_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] CFG_BASE = ADDR_WIDTH'(32'h0800_0000)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [7:0]            layer_idx,
  output logic                  busy,
  output logic                  done,
  output logic                  err,
  output logic                  cfg_valid,
  output logic [8:0]            cfg_pool,
  output logic [7:0]            cfg_numlay,
  output logic [8:0]            cfg_numfiltg,
  output logic [7:0]            cfg_numpat,
  output logic [4:0]            cfg_numfrm,
  output logic [4:0]            cfg_numblk,
  output logic [4:0]            cfg_depblk,
  output logic [3:0]            cfg_lenrow,
  output logic [5:0]            cfg_prio,
  output logic [ADDR_WIDTH-1:0] m_axi_araddr,
  output logic [7:0]            m_axi_arlen,
  output logic [2:0]            m_axi_arsize,
  output logic [1:0]            m_axi_arburst,
  output logic                  m_axi_arvalid,
  input  logic                  m_axi_arready,
  input  logic [31:0]           m_axi_rdata,
  input  logic [1:0]            m_axi_rresp,
  input  logic                  m_axi_rlast,
  input  logic                  m_axi_rvalid,
  output logic                  m_axi_rready
);

  typedef struct packed {
    logic [5:0] prio;
    logic [3:0] lenrow;
    logic [4:0] depblk;
    logic [4:0] numblk;
    logic [4:0] numfrm;
    logic [7:0] numpat;
    logic [8:0] numfiltg;
    logic [7:0] numlay;
    logic [8:0] pool;
  } cfg_word_t;

  typedef enum logic [1:0] {
    IDLE,
    ADDR,
    DATA
  } state_t;

  state_t                  state_q, state_d;
  logic                    beat_q, beat_d;
  logic                    fault_q, fault_d;
  logic [31:0]             lo_q, lo_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic                    done_q, done_d;
  logic                    err_q, err_d;
  logic                    valid_q, valid_d;
  cfg_word_t               cfg_q, cfg_d;
  logic [ADDR_WIDTH-1:0]   offs;
  logic                    bad_resp;
  logic                    unused_hi;

  assign offs      = ADDR_WIDTH'({layer_idx, 3'b000});
  assign bad_resp  = (m_axi_rresp != 2'b00);
  // word[63:59] carries nothing we decode
  assign unused_hi = ^m_axi_rdata[31:27];

  always_comb begin
    state_d = state_q;
    beat_d  = beat_q;
    fault_d = fault_q;
    lo_d    = lo_q;
    addr_d  = addr_q;
    done_d  = 1'b0;
    err_d   = 1'b0;
    valid_d = valid_q;
    cfg_d   = cfg_q;
    unique case (state_q)
      IDLE: begin
        // a pulse cycle still belongs to the previous fetch
        if (start && !done_q && !err_q) begin
          addr_d  = CFG_BASE + offs;
          beat_d  = 1'b0;
          fault_d = 1'b0;
          state_d = ADDR;
        end
      end
      ADDR: begin
        if (m_axi_arready) begin
          state_d = DATA;
        end
      end
      DATA: begin
        if (m_axi_rvalid) begin
          if (!beat_q) begin
            lo_d = m_axi_rdata;
            if (m_axi_rlast) begin
              err_d   = 1'b1;
              state_d = IDLE;
            end else begin
              beat_d  = 1'b1;
              fault_d = fault_q | bad_resp;
            end
          end else begin
            beat_d  = 1'b0;
            state_d = IDLE;
            if (fault_q || bad_resp || !m_axi_rlast) begin
              err_d = 1'b1;
            end else begin
              done_d  = 1'b1;
              valid_d = 1'b1;
              cfg_d   = cfg_word_t'({m_axi_rdata[26:0], lo_q});
            end
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      beat_q  <= 1'b0;
      fault_q <= 1'b0;
      lo_q    <= '0;
      addr_q  <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      valid_q <= 1'b0;
      cfg_q   <= '0;
    end else begin
      state_q <= state_d;
      beat_q  <= beat_d;
      fault_q <= fault_d;
      lo_q    <= lo_d;
      addr_q  <= addr_d;
      done_q  <= done_d;
      err_q   <= err_d;
      valid_q <= valid_d;
      cfg_q   <= cfg_d;
    end
  end

  assign busy          = (state_q != IDLE);
  assign done          = done_q;
  assign err           = err_q;
  assign cfg_valid     = valid_q;
  assign cfg_pool      = cfg_q.pool;
  assign cfg_numlay    = cfg_q.numlay;
  assign cfg_numfiltg  = cfg_q.numfiltg;
  assign cfg_numpat    = cfg_q.numpat;
  assign cfg_numfrm    = cfg_q.numfrm;
  assign cfg_numblk    = cfg_q.numblk;
  assign cfg_depblk    = cfg_q.depblk;
  assign cfg_lenrow    = cfg_q.lenrow;
  assign cfg_prio      = cfg_q.prio;
  assign m_axi_araddr  = addr_q;
  assign m_axi_arlen   = 8'd1;
  assign m_axi_arsize  = 3'b010;
  assign m_axi_arburst = 2'b01;
  assign m_axi_arvalid = (state_q == ADDR);
  assign m_axi_rready  = (state_q == DATA);

endmodule

// File: tb/tb_cfg_fetch.sv
// Directed bench for cfg_fetch: an AXI read slave driven by hand
// around a field-slice model of the 64-bit config word.
module tb_cfg_fetch;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [7:0]  layer_idx;
  logic        busy, done, err, cfg_valid;
  logic [8:0]  cfg_pool, cfg_numfiltg;
  logic [7:0]  cfg_numlay, cfg_numpat;
  logic [4:0]  cfg_numfrm, cfg_numblk, cfg_depblk;
  logic [3:0]  cfg_lenrow;
  logic [5:0]  cfg_prio;
  logic [31:0] m_axi_araddr;
  logic [7:0]  m_axi_arlen;
  logic [2:0]  m_axi_arsize;
  logic [1:0]  m_axi_arburst;
  logic        m_axi_arvalid, m_axi_arready;
  logic [31:0] m_axi_rdata;
  logic [1:0]  m_axi_rresp;
  logic        m_axi_rlast, m_axi_rvalid, m_axi_rready;
  logic [58:0] cfg_all;

  int checks = 0;
  int errors = 0;
  int ar_cnt = 0;
  int done_cnt = 0;
  int err_cnt = 0;
  int both_cnt = 0;
  int exp_done = 0;
  int exp_err = 0;
  logic [58:0] exp_cfg;
  logic        exp_valid;

  localparam logic [63:0] W1 = 64'h065F_F0BC_3C0E_0E0A;
  localparam logic [63:0] W2 = 64'h0123_4567_89AB_CDEF;
  localparam logic [63:0] W3 = 64'hFEDC_BA98_7654_3210;
  localparam logic [63:0] W4 = 64'h5A5A_A5A5_C3C3_3C3C;

  cfg_fetch dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .start         (start),
    .layer_idx     (layer_idx),
    .busy          (busy),
    .done          (done),
    .err           (err),
    .cfg_valid     (cfg_valid),
    .cfg_pool      (cfg_pool),
    .cfg_numlay    (cfg_numlay),
    .cfg_numfiltg  (cfg_numfiltg),
    .cfg_numpat    (cfg_numpat),
    .cfg_numfrm    (cfg_numfrm),
    .cfg_numblk    (cfg_numblk),
    .cfg_depblk    (cfg_depblk),
    .cfg_lenrow    (cfg_lenrow),
    .cfg_prio      (cfg_prio),
    .m_axi_araddr  (m_axi_araddr),
    .m_axi_arlen   (m_axi_arlen),
    .m_axi_arsize  (m_axi_arsize),
    .m_axi_arburst (m_axi_arburst),
    .m_axi_arvalid (m_axi_arvalid),
    .m_axi_arready (m_axi_arready),
    .m_axi_rdata   (m_axi_rdata),
    .m_axi_rresp   (m_axi_rresp),
    .m_axi_rlast   (m_axi_rlast),
    .m_axi_rvalid  (m_axi_rvalid),
    .m_axi_rready  (m_axi_rready)
  );

  assign cfg_all = {cfg_prio, cfg_lenrow, cfg_depblk, cfg_numblk,
                    cfg_numfrm, cfg_numpat, cfg_numfiltg, cfg_numlay,
                    cfg_pool};

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (m_axi_arvalid && m_axi_arready) ar_cnt++;
    if (done) done_cnt++;
    if (err) err_cnt++;
    if (done && err) both_cnt++;
  end

  task automatic check(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_fetch(input logic [7:0] idx, input logic [63:0] w,
                           input int ar_wait, input int gap,
                           input logic [1:0] resp1, input logic last0,
                           input logic restart, input string tag);
    logic [31:0] exp_addr;
    exp_addr = 32'h0800_0000 + {21'd0, idx, 3'b000};
    start = 1'b1;
    layer_idx = idx;
    tick();
    start = 1'b0;
    layer_idx = ~idx;
    for (int i = 0; i < ar_wait; i++) begin
      check({tag, " arvalid held"}, 64'(m_axi_arvalid), 64'd1);
      check({tag, " araddr held"}, 64'(m_axi_araddr), 64'(exp_addr));
      tick();
    end
    check({tag, " araddr"}, 64'(m_axi_araddr), 64'(exp_addr));
    m_axi_arready = 1'b1;
    tick();
    m_axi_arready = 1'b0;
    check({tag, " arvalid drop"}, 64'(m_axi_arvalid), 64'd0);
    m_axi_rvalid = 1'b1;
    m_axi_rdata = w[31:0];
    m_axi_rresp = 2'b00;
    m_axi_rlast = last0;
    tick();
    m_axi_rvalid = 1'b0;
    m_axi_rlast = 1'b0;
    if (last0) begin
      exp_err++;
      check({tag, " err"}, 64'(err), 64'd1);
      check({tag, " done"}, 64'(done), 64'd0);
      check({tag, " idle"}, 64'(busy), 64'd0);
      check({tag, " cfg kept"}, 64'(cfg_all), 64'(exp_cfg));
      tick();
      check({tag, " err pulse"}, 64'(err), 64'd0);
      return;
    end
    for (int i = 0; i < gap; i++) begin
      if (restart && i == 0) start = 1'b1;
      tick();
      start = 1'b0;
      check({tag, " no done in gap"}, 64'(done), 64'd0);
    end
    m_axi_rvalid = 1'b1;
    m_axi_rdata = w[63:32];
    m_axi_rresp = resp1;
    m_axi_rlast = 1'b1;
    tick();
    m_axi_rvalid = 1'b0;
    m_axi_rlast = 1'b0;
    m_axi_rresp = 2'b00;
    if (resp1 == 2'b00) begin
      exp_done++;
      exp_cfg = w[58:0];
      exp_valid = 1'b1;
      check({tag, " done"}, 64'(done), 64'd1);
      check({tag, " err"}, 64'(err), 64'd0);
    end else begin
      exp_err++;
      check({tag, " err"}, 64'(err), 64'd1);
      check({tag, " done"}, 64'(done), 64'd0);
    end
    check({tag, " cfg"}, 64'(cfg_all), 64'(exp_cfg));
    check({tag, " cfg_valid"}, 64'(cfg_valid), 64'(exp_valid));
    tick();
    check({tag, " pulse end"}, 64'({done, err, busy}), 64'd0);
  endtask

  initial begin
    int ar0;
    rst_n = 1'b0;
    start = 1'b0;
    layer_idx = 8'd0;
    m_axi_arready = 1'b0;
    m_axi_rdata = '0;
    m_axi_rresp = 2'b00;
    m_axi_rlast = 1'b0;
    m_axi_rvalid = 1'b0;
    exp_cfg = '0;
    exp_valid = 1'b0;
    repeat (2) tick();
    check("rst flags", 64'({busy, done, err, cfg_valid}), 64'd0);
    check("rst axi", 64'({m_axi_arvalid, m_axi_rready}), 64'd0);
    check("rst araddr", 64'(m_axi_araddr), 64'd0);
    check("rst cfg", 64'(cfg_all), 64'd0);
    check("ar consts", 64'({m_axi_arlen, m_axi_arsize, m_axi_arburst}),
          64'({8'd1, 3'b010, 2'b01}));
    rst_n = 1'b1;
    tick();

    // minimum latency, everything tied ready/valid
    m_axi_arready = 1'b1;
    m_axi_rvalid = 1'b1;
    m_axi_rdata = W1[31:0];
    start = 1'b1;
    layer_idx = 8'd0;
    tick();
    start = 1'b0;
    check("lat arvalid", 64'({m_axi_arvalid, busy}), 64'b11);
    check("lat araddr", 64'(m_axi_araddr), 64'h0800_0000);
    tick();
    check("lat rready", 64'({m_axi_arvalid, m_axi_rready}), 64'b01);
    tick();
    check("lat no done", 64'(done), 64'd0);
    m_axi_rdata = W1[63:32];
    m_axi_rlast = 1'b1;
    tick();
    check("lat done", 64'({done, err, busy, cfg_valid}), 64'b1001);
    check("w1 pool", 64'(cfg_pool), 64'd10);
    check("w1 numlay", 64'(cfg_numlay), 64'd7);
    check("w1 numfiltg", 64'(cfg_numfiltg), 64'd7);
    check("w1 numpat", 64'(cfg_numpat), 64'd15);
    check("w1 numfrm", 64'(cfg_numfrm), 64'd15);
    check("w1 numblk", 64'(cfg_numblk), 64'd1);
    check("w1 depblk", 64'(cfg_depblk), 64'd31);
    check("w1 lenrow", 64'(cfg_lenrow), 64'd15);
    check("w1 prio", 64'(cfg_prio), 64'h32);
    start = 1'b1;
    tick();
    start = 1'b0;
    m_axi_arready = 1'b0;
    m_axi_rvalid = 1'b0;
    m_axi_rlast = 1'b0;
    check("done pulse", 64'(done), 64'd0);
    check("start on done ignored", 64'({busy, m_axi_arvalid}), 64'd0);
    tick();
    check("still idle", 64'(busy), 64'd0);
    exp_done = 1;
    exp_cfg = W1[58:0];
    exp_valid = 1'b1;

    run_fetch(8'd255, W2, 5, 0, 2'b00, 1'b0, 1'b0, "l255");
    check("l255 addr", 64'(m_axi_araddr), 64'h0800_07F8);
    run_fetch(8'd3, W3, 0, 0, 2'b10, 1'b0, 1'b0, "slverr");
    run_fetch(8'd4, W3, 1, 0, 2'b00, 1'b1, 1'b0, "early last");
    run_fetch(8'd5, W3, 0, 0, 2'b00, 1'b0, 1'b0, "after fault");
    ar0 = ar_cnt;
    run_fetch(8'd17, W4, 0, 3, 2'b00, 1'b0, 1'b1, "restart");
    check("restart single ar", 64'(ar_cnt - ar0), 64'd1);

    // reset after beat 0 of a fetch
    start = 1'b1;
    layer_idx = 8'd9;
    tick();
    start = 1'b0;
    m_axi_arready = 1'b1;
    tick();
    m_axi_arready = 1'b0;
    m_axi_rvalid = 1'b1;
    m_axi_rdata = W1[31:0];
    tick();
    m_axi_rvalid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    check("mid rst flags", 64'({busy, done, err, cfg_valid}), 64'd0);
    check("mid rst axi", 64'({m_axi_arvalid, m_axi_rready}), 64'd0);
    check("mid rst araddr", 64'(m_axi_araddr), 64'd0);
    check("mid rst cfg", 64'(cfg_all), 64'd0);
    tick();
    #2;
    rst_n = 1'b1;
    exp_cfg = '0;
    exp_valid = 1'b0;
    tick();
    run_fetch(8'd9, W2, 2, 1, 2'b00, 1'b0, 1'b0, "post rst");

    tick();
    check("done count", 64'(done_cnt), 64'(exp_done));
    check("err count", 64'(err_cnt), 64'(exp_err));
    check("done and err", 64'(both_cnt), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
